// File: rtl/dsp_controller.sv
// Fetch/decode sequencer for a TMS32010-style datapath: fetches program words, decodes them and
// drives every mux/shift/ALU select and register write enable the datapath needs.
module dsp_controller #(
  parameter int PC_W    = 12,
  parameter int DADDR_W = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic [15:0]        prog_data_i,
  input  logic               acc_zero_i,
  output logic [PC_W-1:0]    prog_addr_o,
  output logic [DADDR_W-1:0] ram_addr_o,
  output logic               ram_we_o,
  output logic               t_en_o,
  output logic               p_en_o,
  output logic               acc_en_o,
  output logic [3:0]         aluShifter_ctrl_o,
  output logic [1:0]         aluInMux_ctrl_o,
  output logic [2:0]         alu_ctrl_o,
  output logic [2:0]         accumInMux_ctrl_o,
  output logic [2:0]         accumShifter_ctrl_o,
  output logic [7:0]         imm_o,
  output logic               illegal_o
);

  localparam logic [15:0] IR_NOP  = 16'h7F80;
  localparam logic [15:0] IR_PAC  = 16'h7F8E;
  localparam logic [15:0] IR_APAC = 16'h7F8F;
  localparam logic [15:0] IR_B    = 16'hF900;
  localparam logic [15:0] IR_BZ   = 16'hF600;

  localparam logic [1:0] ALUIN_SHIFT = 2'd0;
  localparam logic [1:0] ALUIN_P     = 2'd1;
  localparam logic [2:0] ALU_ADD     = 3'd0;
  localparam logic [2:0] ALU_SUB     = 3'd1;
  localparam logic [2:0] ACCIN_ALU   = 3'd0;
  localparam logic [2:0] ACCIN_SHIFT = 3'd1;
  localparam logic [2:0] ACCIN_P     = 3'd2;
  localparam logic [2:0] ACCIN_IMM   = 3'd4;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_BRANCH
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_LAC,
    OP_SACL,
    OP_LT,
    OP_MPY,
    OP_LACK,
    OP_PAC,
    OP_APAC,
    OP_NOP,
    OP_B,
    OP_BZ,
    OP_ILLEGAL
  } op_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  op_e             op;
  logic            branchTaken;

  // Full-word encodings are matched first; direct-address forms ignore ir[7].
  always_comb begin
    op = OP_ILLEGAL;
    if (ir_q == IR_NOP) begin
      op = OP_NOP;
    end else if (ir_q == IR_PAC) begin
      op = OP_PAC;
    end else if (ir_q == IR_APAC) begin
      op = OP_APAC;
    end else if (ir_q == IR_B) begin
      op = OP_B;
    end else if (ir_q == IR_BZ) begin
      op = OP_BZ;
    end else begin
      case (ir_q[15:12])
        4'h0: op = OP_ADD;
        4'h1: op = OP_SUB;
        4'h2: op = OP_LAC;
        default: begin
          case (ir_q[15:8])
            8'h50:   op = OP_SACL;
            8'h6A:   op = OP_LT;
            8'h6D:   op = OP_MPY;
            8'h7E:   op = OP_LACK;
            default: op = OP_ILLEGAL;
          endcase
        end
      endcase
    end
  end

  assign branchTaken = (op == OP_B) || ((op == OP_BZ) && acc_zero_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= IR_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // The second word of a branch is read in BRANCH, so pc already points at it there.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (run_i) begin
          ir_d    = prog_data_i;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = ((op == OP_B) || (op == OP_BZ)) ? S_BRANCH : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        pc_d    = branchTaken ? prog_data_i[PC_W-1:0] : pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    prog_addr_o         = pc_q;
    ram_addr_o          = '0;
    ram_we_o            = 1'b0;
    t_en_o              = 1'b0;
    p_en_o              = 1'b0;
    acc_en_o            = 1'b0;
    aluShifter_ctrl_o   = 4'd0;
    aluInMux_ctrl_o     = ALUIN_SHIFT;
    alu_ctrl_o          = ALU_ADD;
    accumInMux_ctrl_o   = ACCIN_ALU;
    accumShifter_ctrl_o = 3'd0;
    imm_o               = 8'd0;
    illegal_o           = 1'b0;

    // RAM address is held through EXEC so SACL writes the location that was read.
    if ((state_q == S_DECODE) || (state_q == S_EXEC)) begin
      ram_addr_o = ir_q[DADDR_W-1:0];
    end

    if (state_q == S_EXEC) begin
      case (op)
        OP_ADD: begin
          aluShifter_ctrl_o = ir_q[11:8];
          aluInMux_ctrl_o   = ALUIN_SHIFT;
          alu_ctrl_o        = ALU_ADD;
          accumInMux_ctrl_o = ACCIN_ALU;
          acc_en_o          = 1'b1;
        end
        OP_SUB: begin
          aluShifter_ctrl_o = ir_q[11:8];
          aluInMux_ctrl_o   = ALUIN_SHIFT;
          alu_ctrl_o        = ALU_SUB;
          accumInMux_ctrl_o = ACCIN_ALU;
          acc_en_o          = 1'b1;
        end
        OP_LAC: begin
          aluShifter_ctrl_o = ir_q[11:8];
          accumInMux_ctrl_o = ACCIN_SHIFT;
          acc_en_o          = 1'b1;
        end
        OP_SACL: begin
          ram_we_o            = 1'b1;
          accumShifter_ctrl_o = 3'd0;
        end
        OP_LT: begin
          t_en_o = 1'b1;
        end
        OP_MPY: begin
          p_en_o = 1'b1;
        end
        OP_LACK: begin
          accumInMux_ctrl_o = ACCIN_IMM;
          imm_o             = ir_q[7:0];
          acc_en_o          = 1'b1;
        end
        OP_PAC: begin
          accumInMux_ctrl_o = ACCIN_P;
          acc_en_o          = 1'b1;
        end
        OP_APAC: begin
          aluInMux_ctrl_o   = ALUIN_P;
          alu_ctrl_o        = ALU_ADD;
          accumInMux_ctrl_o = ACCIN_ALU;
          acc_en_o          = 1'b1;
        end
        OP_ILLEGAL: begin
          illegal_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Register write enables are mutually exclusive and confined to EXEC.
  enablesOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({ram_we_o, t_en_o, p_en_o, acc_en_o}));
  enablesOnlyInExec: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != S_EXEC) |-> !(ram_we_o || t_en_o || p_en_o || acc_en_o || illegal_o));

endmodule

// File: tb/tb_dsp_controller.sv
// Self-checking bench for dsp_controller: an instruction-level model predicts every output on every
// cycle, with directed programs pinned by literal expectations and a randomized program run.
module tb_dsp_controller;

  typedef struct packed {
    logic [11:0] pa;
    logic [6:0]  ra;
    logic        we;
    logic        t;
    logic        p;
    logic        acc;
    logic [3:0]  ash;
    logic [1:0]  ain;
    logic [2:0]  alu;
    logic [2:0]  accin;
    logic [2:0]  accsh;
    logic [7:0]  imm;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] prog_data;
  logic        acc_zero;
  logic [11:0] prog_addr;
  logic [6:0]  ram_addr;
  logic        ram_we, t_en, p_en, acc_en;
  logic [3:0]  aluShifter_ctrl;
  logic [1:0]  aluInMux_ctrl;
  logic [2:0]  alu_ctrl;
  logic [2:0]  accumInMux_ctrl;
  logic [2:0]  accumShifter_ctrl;
  logic [7:0]  imm;
  logic        illegal;

  logic [15:0] rom [0:4095];
  exp_t        expv;
  exp_t        hist [0:8191];
  logic        chk;
  logic [11:0] m_pc;
  int          nCmp;
  int          nErr;
  int          cycN;
  int          base;

  dsp_controller #(.PC_W(12), .DADDR_W(7)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .run_i              (run),
    .prog_data_i        (prog_data),
    .acc_zero_i         (acc_zero),
    .prog_addr_o        (prog_addr),
    .ram_addr_o         (ram_addr),
    .ram_we_o           (ram_we),
    .t_en_o             (t_en),
    .p_en_o             (p_en),
    .acc_en_o           (acc_en),
    .aluShifter_ctrl_o  (aluShifter_ctrl),
    .aluInMux_ctrl_o    (aluInMux_ctrl),
    .alu_ctrl_o         (alu_ctrl),
    .accumInMux_ctrl_o  (accumInMux_ctrl),
    .accumShifter_ctrl_o(accumShifter_ctrl),
    .imm_o              (imm),
    .illegal_o          (illegal)
  );

  assign prog_data = rom[prog_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nErr++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t sampleDut();
    exp_t e;
    e.pa    = prog_addr;
    e.ra    = ram_addr;
    e.we    = ram_we;
    e.t     = t_en;
    e.p     = p_en;
    e.acc   = acc_en;
    e.ash   = aluShifter_ctrl;
    e.ain   = aluInMux_ctrl;
    e.alu   = alu_ctrl;
    e.accin = accumInMux_ctrl;
    e.accsh = accumShifter_ctrl;
    e.imm   = imm;
    e.ill   = illegal;
    return e;
  endfunction

  function automatic exp_t fetchExp(input logic [11:0] pc);
    exp_t e;
    e    = '0;
    e.pa = pc;
    return e;
  endfunction

  // Instruction table: what the datapath must see in the execute cycle of word w.
  function automatic exp_t execExp(input logic [15:0] w, input logic [11:0] pc);
    exp_t e;
    e    = '0;
    e.pa = pc;
    e.ra = w[6:0];
    if (w == 16'h7F80) begin
    end else if (w == 16'h7F8E) begin
      e.accin = 3'd2; e.acc = 1'b1;
    end else if (w == 16'h7F8F) begin
      e.ain = 2'd1; e.acc = 1'b1;
    end else if (w[15:12] == 4'h0) begin
      e.ash = w[11:8]; e.acc = 1'b1;
    end else if (w[15:12] == 4'h1) begin
      e.ash = w[11:8]; e.alu = 3'd1; e.acc = 1'b1;
    end else if (w[15:12] == 4'h2) begin
      e.ash = w[11:8]; e.accin = 3'd1; e.acc = 1'b1;
    end else if (w[15:8] == 8'h50) begin
      e.we = 1'b1;
    end else if (w[15:8] == 8'h6A) begin
      e.t = 1'b1;
    end else if (w[15:8] == 8'h6D) begin
      e.p = 1'b1;
    end else if (w[15:8] == 8'h7E) begin
      e.accin = 3'd4; e.imm = w[7:0]; e.acc = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    case ($urandom_range(0, 12))
      0:       w = {4'h0, 4'($urandom), 8'($urandom)};
      1:       w = {4'h1, 4'($urandom), 8'($urandom)};
      2:       w = {4'h2, 4'($urandom), 8'($urandom)};
      3:       w = {8'h50, 8'($urandom)};
      4:       w = {8'h6A, 8'($urandom)};
      5:       w = {8'h6D, 8'($urandom)};
      6:       w = {8'h7E, 8'($urandom)};
      7:       w = 16'h7F8E;
      8:       w = 16'h7F8F;
      9:       w = 16'h7F80;
      10:      w = 16'hF900;
      11:      w = 16'hF600;
      default: w = 16'($urandom);
    endcase
    return w;
  endfunction

  function automatic exp_t h(input int k);
    return hist[(base + k) % 8192];
  endfunction

  // Single compare point, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (chk) begin
      exp_t a;
      a = sampleDut();
      checkOutput("prog_addr", 64'(a.pa), 64'(expv.pa));
      checkOutput("ram_addr", 64'(a.ra), 64'(expv.ra));
      checkOutput("ram_we", 64'(a.we), 64'(expv.we));
      checkOutput("t_en", 64'(a.t), 64'(expv.t));
      checkOutput("p_en", 64'(a.p), 64'(expv.p));
      checkOutput("acc_en", 64'(a.acc), 64'(expv.acc));
      checkOutput("aluShifter", 64'(a.ash), 64'(expv.ash));
      checkOutput("aluInMux", 64'(a.ain), 64'(expv.ain));
      checkOutput("alu_ctrl", 64'(a.alu), 64'(expv.alu));
      checkOutput("accumInMux", 64'(a.accin), 64'(expv.accin));
      checkOutput("accumShifter", 64'(a.accsh), 64'(expv.accsh));
      checkOutput("imm", 64'(a.imm), 64'(expv.imm));
      checkOutput("illegal", 64'(a.ill), 64'(expv.ill));
      hist[cycN % 8192] = a;
      cycN++;
    end
  end

  task automatic fillNop();
    for (int i = 0; i < 4096; i++) rom[i] = 16'h7F80;
  endtask

  task automatic doReset();
    chk   = 1'b0;
    run   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("resetOutputs", 64'(sampleDut()), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_pc = 12'h000;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk      = 1'b1;
      run      = 1'b0;
      acc_zero = 1'($urandom);
      expv     = fetchExp(m_pc);
      @(posedge clk);
      #1;
    end
  endtask

  // One complete instruction starting in FETCH with run high; az is acc_zero during a branch.
  task automatic applyStimulus(input logic az);
    logic [15:0] w;
    logic [15:0] tgt;
    chk      = 1'b1;
    run      = 1'b1;
    acc_zero = 1'($urandom);
    expv     = fetchExp(m_pc);
    w        = rom[m_pc];
    @(posedge clk);
    #1;
    m_pc     = m_pc + 12'd1;
    run      = 1'($urandom);
    acc_zero = 1'($urandom);
    expv     = '0;
    expv.pa  = m_pc;
    expv.ra  = w[6:0];
    @(posedge clk);
    #1;
    run = 1'($urandom);
    if ((w == 16'hF900) || (w == 16'hF600)) begin
      acc_zero = az;
      expv     = fetchExp(m_pc);
      tgt      = rom[m_pc];
      @(posedge clk);
      #1;
      if ((w == 16'hF900) || az) m_pc = tgt[11:0];
      else m_pc = m_pc + 12'd1;
    end else begin
      acc_zero = 1'($urandom);
      expv     = execExp(w, m_pc);
      @(posedge clk);
      #1;
    end
    run = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCmp     = 0;
    nErr     = 0;
    cycN     = 0;
    base     = 0;
    chk      = 1'b0;
    run      = 1'b0;
    acc_zero = 1'b0;
    rst_n    = 1'b0;
    expv     = '0;
    m_pc     = 12'h000;

    // Straight-line program with hand-computed cycle positions.
    fillNop();
    rom[0] = 16'h6A05; rom[1] = 16'h6D06; rom[2] = 16'h7F8E;
    rom[3] = 16'h0305; rom[4] = 16'h1305; rom[5] = 16'hA123;
    rom[6] = 16'h7F80;
    doReset();
    base = cycN;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0);
    checkOutput("ltRamAddrC1", 64'(h(1).ra), 64'd5);
    checkOutput("ltTenC2", 64'(h(2).t), 64'd1);
    checkOutput("mpyRamAddrC4", 64'(h(4).ra), 64'd6);
    checkOutput("mpyPenC5", 64'(h(5).p), 64'd1);
    checkOutput("pacAccEnC8", 64'(h(8).acc), 64'd1);
    checkOutput("pacAccInC8", 64'(h(8).accin), 64'd2);
    checkOutput("addShiftC11", 64'(h(11).ash), 64'd3);
    checkOutput("addAccEnC11", 64'(h(11).acc), 64'd1);
    checkOutput("addAccEnC12", 64'(h(12).acc), 64'd0);
    checkOutput("subAluC14", 64'(h(14).alu), 64'd1);
    checkOutput("illegalC17", 64'(h(17).ill), 64'd1);
    checkOutput("illegalEnC17", 64'({h(17).we, h(17).t, h(17).p, h(17).acc}), 64'd0);
    checkOutput("illegalC18", 64'(h(18).ill), 64'd0);
    checkOutput("nextFetchC18", 64'(h(18).pa), 64'h006);

    // Conditional branch, taken then not taken.
    fillNop();
    rom[12'h000] = 16'hF900; rom[12'h001] = 16'h0010;
    rom[12'h010] = 16'hF600; rom[12'h011] = 16'h0040;
    doReset();
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("bzTakenAddr", 64'(prog_addr), 64'h040);
    applyStimulus(1'b0);
    doReset();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("bzNotTakenAddr", 64'(prog_addr), 64'h012);

    // pc wrap and hold while run is low.
    fillNop();
    rom[12'h000] = 16'hF900; rom[12'h001] = 16'h0FFF;
    doReset();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("pcWrapAddr", 64'(prog_addr), 64'h000);
    idleCycles(5);
    checkOutput("holdAddr", 64'(prog_addr), 64'h000);
    applyStimulus(1'b0);

    // Asynchronous reset in the middle of an ADD execute cycle.
    fillNop();
    rom[0] = 16'h0305;
    doReset();
    chk = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("accEnBeforeReset", 64'(acc_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("accEnAtReset", 64'(acc_en), 64'd0);
    checkOutput("progAddrAtReset", 64'(prog_addr), 64'h000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_pc = 12'h000;
    @(posedge clk);
    #1;
    checkOutput("progAddrAfterReset", 64'(prog_addr), 64'h000);
    applyStimulus(1'b0);

    // Randomized program with random idle gaps and acc_zero.
    for (int i = 0; i < 4096; i++) rom[i] = randWord();
    doReset();
    for (int n = 0; n < 350; n++) begin
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      applyStimulus(1'($urandom));
    end

    chk = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
